// File: rtl/lsb_index_serializer.sv
// Serializes a request vector into one-hot / index beats, lowest set bit first.
// Each accepted beat clears its bit from the remaining mask; a new vector may load as the last beat retires.
module lsb_index_serializer #(
  parameter int WIDTH = 32,
  localparam int IDX_W = $clog2(WIDTH)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  input  logic [WIDTH-1:0] in_vec,
  output logic             in_ready,
  output logic             out_valid,
  output logic [WIDTH-1:0] out_onehot,
  output logic [IDX_W-1:0] out_idx,
  output logic [IDX_W:0]   out_seq,
  output logic             out_last,
  input  logic             out_ready
);

  logic [WIDTH-1:0] mask;
  logic [IDX_W:0]   seq;
  logic             fire;
  logic             load;

  assign out_onehot = mask & (~mask + WIDTH'(1));

  // OR-reduce indices of set bits; exact because out_onehot has at most one bit set.
  always_comb begin
    out_idx = '0;
    for (int unsigned i = 0; i < WIDTH; i++) begin
      if (out_onehot[i]) out_idx = out_idx | IDX_W'(i);
    end
  end

  assign out_valid = |mask;
  assign out_last  = out_valid & ((mask & ~out_onehot) == '0);
  assign out_seq   = seq;
  assign in_ready  = ~out_valid | (out_last & out_ready);

  assign fire = out_valid & out_ready;
  assign load = in_valid & in_ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      mask <= '0;
      seq  <= '0;
    end else if (load) begin
      mask <= in_vec;
      seq  <= '0;
    end else if (fire) begin
      mask <= mask & ~out_onehot;
      seq  <= seq + (IDX_W+1)'(1);
    end
  end

endmodule

// File: tb/tb_lsb_index_serializer.sv
// Bench for lsb_index_serializer: a queue-of-beats model checked every cycle, plus directed literal checks.
module tb_lsb_index_serializer;

  localparam int W  = 32;
  localparam int IW = $clog2(W);

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic [W-1:0]  in_vec;
  logic          in_ready;
  logic          out_valid;
  logic [W-1:0]  out_onehot;
  logic [IW-1:0] out_idx;
  logic [IW:0]   out_seq;
  logic          out_last;
  logic          out_ready;

  int tests = 0;
  int fails = 0;

  typedef struct {
    logic [W-1:0] oh;
    int           idx;
    int           seq;
    bit           last;
  } beat_t;

  beat_t q[$];

  lsb_index_serializer #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_vec(in_vec),
    .in_ready(in_ready), .out_valid(out_valid), .out_onehot(out_onehot),
    .out_idx(out_idx), .out_seq(out_seq), .out_last(out_last),
    .out_ready(out_ready)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Expand a vector into its beats: every set bit, ascending, numbered 0..k-1.
  task automatic model_push(input logic [W-1:0] v);
    int cnt;
    int n;
    beat_t b;
    cnt = $countones(v);
    n = 0;
    for (int i = 0; i < W; i++) begin
      if (v[i]) begin
        b.oh   = W'(1) << i;
        b.idx  = i;
        b.seq  = n;
        b.last = (n == cnt - 1);
        q.push_back(b);
        n++;
      end
    end
  endtask

  // Compare on the falling edge, then advance the model by the upcoming rising edge.
  initial begin
    bit exp_rdy;
    bit fire;
    @(posedge clk);
    forever begin
      @(negedge clk);
      exp_rdy = (q.size() == 0) || (q.size() == 1 && out_ready);
      chk("m_in_ready", in_ready, exp_rdy);
      chk("m_out_valid", out_valid, q.size() != 0);
      if (q.size() != 0) begin
        chk("m_onehot", out_onehot, q[0].oh);
        chk("m_idx", out_idx, q[0].idx);
        chk("m_seq", out_seq, q[0].seq);
        chk("m_last", out_last, q[0].last);
      end else begin
        chk("m_idle_onehot", out_onehot, 0);
        chk("m_idle_last", out_last, 0);
      end
      fire = (q.size() != 0) && out_ready;
      if (!rst_n) begin
        q.delete();
      end else begin
        if (fire) void'(q.pop_front());
        if (in_valid && exp_rdy) model_push(in_vec);
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Present v until accepted; returns just after the loading edge.
  task automatic send(input logic [W-1:0] v);
    int n;
    in_valid = 1'b1;
    in_vec   = v;
    n = 0;
    forever begin
      @(negedge clk);
      if (in_ready) break;
      n++;
      if (n > 200) begin
        tests++;
        fails++;
        $display("FAIL send_timeout: in_ready stuck low, vector %0h", v);
        break;
      end
    end
    step();
    in_valid = 1'b0;
  endtask

  task automatic beat(input string name, input int idx, input int seq, input bit last);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_idx"}, out_idx, idx);
    chk({name, "_onehot"}, out_onehot, W'(1) << idx);
    chk({name, "_seq"}, out_seq, seq);
    chk({name, "_last"}, out_last, last);
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b1; in_vec = '1; out_ready = 1'b1;

    // Reset with a pending full vector: nothing may load.
    step(); chk("rst_valid0", out_valid, 0);
    step(); chk("rst_valid1", out_valid, 0);
    rst_n = 1'b1; in_valid = 1'b0;
    chk("rst_in_ready", in_ready, 1);
    chk("rst_idx", out_idx, 0);
    chk("rst_seq", out_seq, 0);
    step(); chk("rst_post_valid", out_valid, 0);

    // Basic serialize.
    send(32'h8000_0011);
    beat("basic0", 0, 0, 0); step();
    beat("basic1", 4, 1, 0); step();
    beat("basic2", 31, 2, 1); step();
    chk("basic_done", out_valid, 0);

    // Backpressure: the head beat holds while out_ready is low.
    out_ready = 1'b0;
    send(32'h0000_0C00);
    for (int i = 0; i < 5; i++) begin
      beat("bp_hold", 10, 0, 0);
      chk("bp_in_ready", in_ready, 0);
      step();
    end
    out_ready = 1'b1;
    beat("bp_fire", 10, 0, 0); step();
    beat("bp_last", 11, 1, 1); step();
    chk("bp_done", out_valid, 0);

    // Back-to-back: B loads on the edge that retires A's only beat.
    in_valid = 1'b1; in_vec = 32'h1;
    step();
    in_vec = 32'h6;
    beat("b2b_a", 0, 0, 1);
    chk("b2b_ready", in_ready, 1);
    step();
    in_valid = 1'b0;
    beat("b2b_b0", 1, 0, 0); step();
    beat("b2b_b1", 2, 1, 1); step();
    chk("b2b_done", out_valid, 0);

    // Zero vector then full vector.
    send('0);
    chk("zero_valid", out_valid, 0);
    chk("zero_ready", in_ready, 1);
    send('1);
    for (int i = 0; i < W; i++) begin
      beat("full", i, i, i == W - 1);
      step();
    end
    chk("full_done", out_valid, 0);

    // Reset mid-vector discards remaining bits.
    send('1);
    step(); step(); step();
    chk("mid_seq3", out_seq, 3);
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    chk("mid_valid", out_valid, 0);
    chk("mid_seq", out_seq, 0);
    chk("mid_ready", in_ready, 1);
    send(32'h2);
    beat("mid_new", 1, 0, 1); step();
    chk("mid_new_done", out_valid, 0);

    // Randomized traffic; the model process checks every cycle.
    for (int c = 0; c < 3000; c++) begin
      int sel;
      out_ready = ($urandom_range(0, 3) != 0);
      in_valid  = ($urandom_range(0, 2) != 0);
      sel = $urandom_range(0, 9);
      if (sel == 0)      in_vec = '0;
      else if (sel == 1) in_vec = '1;
      else if (sel < 6)  in_vec = $urandom() & $urandom() & $urandom();
      else               in_vec = $urandom();
      rst_n = ($urandom_range(0, 299) != 0);
      step();
    end
    rst_n = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    step(); step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
